// File: rtl/mean_pkg.sv
// Shared definitions for the packer and the downstream mean stage.
package mean_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int DEF_BUS_WIDTH  = 4;
    localparam int DEF_DATA_WIDTH = 6;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sample_packer.sv
// Packs BUS_WIDTH consecutive samples into one word; frames cut short by
// s_last are discarded and counted.
module sample_packer
    import mean_pkg::*;
#(
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data [0:BUS_WIDTH-1],
    output logic [CNT_WIDTH-1:0]  o_drop_cnt,
    output logic                  o_dbg_state
);

    localparam int IDX_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

    if ((BUS_WIDTH < 1) || ((BUS_WIDTH & (BUS_WIDTH - 1)) != 0)) begin : g_bw_check
        $fatal(1, "sample_packer: BUS_WIDTH must be a power of 2");
    end

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_o_valid;
    logic [DATA_WIDTH-1:0] r_buf      [0:BUS_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_out_data [0:BUS_WIDTH-1];

    logic w_accept;
    logic w_last_lane;
    logic w_out_free;
    logic w_load_fill;
    logic w_load_full;
    logic w_drop;

    // Both ports use valid/ready: a beat moves on a rising edge where valid
    // and ready are both high; valid and payload hold until that happens.
    assign s_ready     = !rst && (r_state == FILL);
    assign w_accept    = s_valid && s_ready;
    assign w_last_lane = (r_idx == IDX_W'(BUS_WIDTH - 1));
    assign w_out_free  = !r_o_valid || o_ready;
    assign w_load_fill = w_accept && w_last_lane && w_out_free;
    assign w_load_full = (r_state == FULL) && w_out_free;
    assign w_drop      = w_accept && s_last && !w_last_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FILL;
            r_idx     <= '0;
            r_o_valid <= 1'b0;
        end else begin
            if (r_o_valid && o_ready) begin
                r_o_valid <= 1'b0;
            end
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (w_last_lane) begin
                            r_idx <= '0;
                            if (w_out_free) begin
                                r_o_valid <= 1'b1;
                            end else begin
                                r_state <= FULL;
                            end
                        end else if (s_last) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (w_out_free) begin
                        r_o_valid <= 1'b1;
                        r_idx     <= '0;
                        r_state   <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Payload registers carry no reset; o_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_idx] <= s_data;
        end
        if (w_load_fill) begin
            for (int i = 0; i < BUS_WIDTH - 1; i++) begin
                r_out_data[i] <= r_buf[i];
            end
            r_out_data[BUS_WIDTH-1] <= s_data;
        end else if (w_load_full) begin
            r_out_data <= r_buf;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_drop_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_drop),
        .o_count(o_drop_cnt)
    );

    assign o_valid     = r_o_valid;
    assign o_data      = r_out_data;
    assign o_dbg_state = r_state;

endmodule
